// File: rtl/q_8_34a_ctrl_if.sv
// Control/status bundle between the ones-counter controller and its datapath and requester.
// slave = controller side; master = datapath/requester side.
interface q_8_34a_ctrl_if;
  logic start;
  logic zero;
  logic E;
  logic load_regs;
  logic incr_r2;
  logic shift;
  logic ready;
  logic done;
  logic timeout;

  modport master (
    output start, zero, E,
    input  load_regs, incr_r2, shift, ready, done, timeout
  );

  modport slave (
    input  start, zero, E,
    output load_regs, incr_r2, shift, ready, done, timeout
  );
endinterface

// File: rtl/q_8_34a_ctrl.sv
// Ones-counter ASM controller: sequences load/incr/shift until R1 empties; done pulses when R2 holds the count.
// start is taken only while ready=1 (no queuing); watchdog aborts a stuck run to IDLE with sticky timeout.
module q_8_34a_ctrl #(
  parameter int DATA_SIZE   = 4,
  parameter int TIMEOUT_CYC = 4*DATA_SIZE+8
) (
  input  logic          clk,
  input  logic          rst_b,
  q_8_34a_ctrl_if.slave ctl
);

  localparam int CW = $clog2(TIMEOUT_CYC+1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INCR  = 3'd1,
    SHIFT = 3'd2,
    TEST  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t        state;
  logic [CW-1:0] busy_cnt;
  logic          timeout_q;
  logic          accept;
  logic          wd_expire;

  assign accept    = (state == IDLE) && ctl.start;
  assign wd_expire = (busy_cnt == CW'(TIMEOUT_CYC));

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= IDLE;
      busy_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state == IDLE)
        busy_cnt <= '0;
      else if (!wd_expire)
        busy_cnt <= busy_cnt + CW'(1);

      case (state)
        IDLE: begin
          if (ctl.start) begin
            state     <= INCR;
            timeout_q <= 1'b0;
          end
        end
        INCR: begin
          if (wd_expire) begin
            state     <= IDLE;
            timeout_q <= 1'b1;
          end else begin
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (wd_expire) begin
            state     <= IDLE;
            timeout_q <= 1'b1;
          end else begin
            state <= TEST;
          end
        end
        TEST: begin
          // E before zero: a last shift that emits a 1 and empties R1 must still be counted
          if (wd_expire) begin
            state     <= IDLE;
            timeout_q <= 1'b1;
          end else if (ctl.E) begin
            state <= INCR;
          end else if (ctl.zero) begin
            state <= DONE;
          end else begin
            state <= SHIFT;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // load_regs is gated by rst_b so it stays low while reset is held even if start is high
  assign ctl.load_regs = accept && rst_b;
  assign ctl.incr_r2   = (state == INCR);
  assign ctl.shift     = (state == SHIFT);
  assign ctl.done      = (state == DONE);
  assign ctl.ready     = (state == IDLE);
  assign ctl.timeout   = timeout_q;

endmodule

// File: tb/tb_q_8_34a_ctrl.sv
// Bench for q_8_34a_ctrl: datapath model drives zero/E, scoreboard of expected results, negedge monitor.
module tb_q_8_34a_ctrl;

  localparam int TO = 24;

  typedef struct {
    bit is_to;
    int r2;
    int lat;
  } exp_t;

  logic clk;
  logic rst_b;
  logic [3:0] data_in;
  logic stuck;
  logic [3:0] r1, r2;
  logic e_q;
  int cyc;
  int checks;
  int failures;
  exp_t q[$];

  int acc_t;
  bit in_run;
  bit prev_ready;
  bit prev_done;
  string trace;
  string last_trace;

  q_8_34a_ctrl_if bus();

  q_8_34a_ctrl #(.DATA_SIZE(4), .TIMEOUT_CYC(TO)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .ctl   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // datapath: R1 shifts right, LSB goes to E
  always @(posedge clk) begin
    if (bus.load_regs) begin
      r1 <= data_in;
      r2 <= 4'hF;
    end
    if (bus.incr_r2) r2 <= r2 + 4'd1;
    if (bus.shift) begin
      e_q <= r1[0];
      r1  <= r1 >> 1;
    end
  end

  assign bus.zero = stuck ? 1'b0 : (r1 == 4'd0);
  assign bus.E    = stuck ? 1'b0 : e_q;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%s expected=%s", name, act, exp);
    end
  endtask

  // Reference: one INCR to wrap R2 plus one per 1-bit; shifts run past the top set bit
  // (one extra shift because the top bit leaves as E=1 and triggers another INCR/SHIFT/TEST).
  function automatic exp_t model(input logic [3:0] d, input bit stk);
    exp_t e;
    int k, p, shifts;
    k = 0;
    p = -1;
    for (int i = 0; i < 4; i++) begin
      if (d[i]) begin
        k++;
        p = i;
      end
    end
    shifts = (d == 4'd0) ? 1 : p + 2;
    e.is_to = stk;
    e.r2    = stk ? 0 : k;
    e.lat   = stk ? TO + 2 : (k + 1) + 2 * shifts + 1;
    return e;
  endfunction

  // monitor
  initial begin
    prev_ready = 1'b1;
    prev_done  = 1'b0;
    in_run     = 1'b0;
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_b) begin
      prev_ready = 1'b1;
      prev_done  = 1'b0;
      in_run     = 1'b0;
    end else begin
      if (bus.load_regs) begin
        acc_t  = cyc;
        trace  = "";
        in_run = 1'b1;
      end else if (in_run && !bus.ready) begin
        if (bus.incr_r2)    trace = {trace, "I"};
        else if (bus.shift) trace = {trace, "S"};
        else if (bus.done)  trace = {trace, "D"};
        else                trace = {trace, "T"};
      end
      if (bus.start && !bus.ready)
        chk("busy_start_ignored", int'(bus.load_regs), 0);
      if (bus.done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = q.pop_front();
          chk("done_kind", 0, int'(e.is_to));
          chk("done_r2", int'(r2), e.r2);
          chk("done_latency", cyc - acc_t, e.lat);
          chk("done_timeout_flag", int'(bus.timeout), 0);
        end
        last_trace = trace;
        in_run     = 1'b0;
      end
      if (bus.ready && !prev_ready && !prev_done) begin
        if (q.size() == 0) begin
          chk("unexpected_abort", 1, 0);
        end else begin
          e = q.pop_front();
          chk("abort_kind", 1, int'(e.is_to));
          chk("abort_latency", cyc - acc_t, e.lat);
          chk("abort_timeout_flag", int'(bus.timeout), 1);
        end
        in_run = 1'b0;
      end
      prev_ready = bus.ready;
      prev_done  = bus.done;
    end
  end

  // called at posedge+1; returns the number of cycles waited before the accept edge
  task automatic issue(input logic [3:0] d, input bit stk, output int n);
    data_in   = d;
    stuck     = stk;
    bus.start = 1'b1;
    q.push_back(model(d, stk));
    n = 0;
    #1;
    while (!bus.load_regs && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) chk("accept_bound", n, 0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input bit spam);
    int n;
    n = 0;
    while (!(bus.ready && q.size() == 0) && n < 300) begin
      @(posedge clk);
      #1;
      if (spam) bus.start = (!bus.ready && !bus.done) ? 1'($urandom % 2) : 1'b0;
      n++;
    end
    bus.start = 1'b0;
    if (n >= 300) chk("idle_bound", n, 0);
  endtask

  initial begin
    int n;
    logic [3:0] d;
    bit stk;
    checks    = 0;
    failures  = 0;
    cyc       = 0;
    rst_b     = 1'b0;
    stuck     = 1'b0;
    data_in   = 4'd0;
    bus.start = 1'b0;
    #3;
    chk("rst_ready", int'(bus.ready), 1);
    chk("rst_busy_outs", int'({bus.load_regs, bus.incr_r2, bus.shift, bus.done}), 0);
    chk("rst_timeout", int'(bus.timeout), 0);
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    @(posedge clk);
    #1;

    issue(4'b1010, 1'b0, n);
    wait_idle(1'b0);
    chk_str("trace_1010", last_trace, "ISTSTISTSTISTD");

    issue(4'b0000, 1'b0, n);
    wait_idle(1'b0);
    chk_str("trace_0000", last_trace, "ISTD");

    issue(4'b1111, 1'b0, n);
    n = 0;
    while (!bus.done && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) chk("done_bound", n, 0);
    issue(4'b0110, 1'b0, n);
    chk("accept_after_done_wait", n, 1);
    wait_idle(1'b0);

    issue(4'b0011, 1'b1, n);
    wait_idle(1'b0);
    stuck = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("timeout_sticky", int'(bus.timeout), 1);
    issue(4'b0101, 1'b0, n);
    chk("timeout_cleared_on_start", int'(bus.timeout), 0);
    wait_idle(1'b0);

    // asynchronous reset in the middle of a run, with start held high
    issue(4'b1101, 1'b0, n);
    n = 0;
    while (!bus.shift && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("reached_shift", int'(bus.shift), 1);
    #2;
    bus.start = 1'b1;
    rst_b     = 1'b0;
    #1;
    q.delete();
    chk("midrun_rst_ready", int'(bus.ready), 1);
    chk("midrun_rst_busy_outs", int'({bus.load_regs, bus.incr_r2, bus.shift, bus.done}), 0);
    chk("midrun_rst_timeout", int'(bus.timeout), 0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    rst_b     = 1'b1;
    @(posedge clk);
    #1;
    issue(4'b1001, 1'b1, n);
    wait_idle(1'b0);
    stuck = 1'b0;

    for (int i = 0; i < 40; i++) begin
      d   = 4'($urandom % 16);
      stk = ($urandom % 8) == 0;
      issue(d, stk, n);
      wait_idle(!stk);
      stuck = 1'b0;
      repeat ($urandom % 3) @(posedge clk);
      #1;
    end

    chk("scoreboard_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_time_limit actual=expired required=finish");
    $fatal(1, "time limit");
  end

endmodule
